// File: rtl/clock_time_core.sv
// clock_time_core: BCD time-of-day counter with two-key set mode and minute alarm
module clock_time_core #(
  parameter int HOUR_MAX   = 23,
  parameter int ALARM_SECS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_s,
  input  logic       tick_beep,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       alarm_en,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] set_mode,
  output logic       sec_pulse,
  output logic       beep
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SET_M = 2'd1;
  localparam logic [1:0] SET_H = 2'd2;
  localparam logic [7:0] HOUR_TOP   = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));
  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);

  // Increment a two-digit BCD value, wrapping to 00 after top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic       tick_s_q, key_mode_q, key_inc_q;
  logic [1:0] state_q, state_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       sec_pulse_q, sec_pulse_d, beep_q, beep_d;
  logic       sec_ev, mode_ev, inc_ev, is_run, tick, set_inc;
  logic       sec_carry, min_carry, alarm_active, alarm_match, alarm_stop;

  assign sec_ev       = tick_s & ~tick_s_q;
  assign mode_ev      = key_mode & ~key_mode_q;
  assign inc_ev       = key_inc & ~key_inc_q;
  assign is_run       = state_q == RUN;
  assign tick         = is_run & sec_ev;
  assign set_inc      = inc_ev & ~mode_ev;
  assign sec_carry    = sec_q == 8'h59;
  assign min_carry    = min_q == 8'h59;
  assign alarm_active = alarm_cnt_q != 8'd0;

  // Next-state for mode, time fields, alarm counter and output strobes.
  always_comb begin
    state_d     = mode_ev ? (state_q == RUN ? SET_M : state_q == SET_M ? SET_H : RUN) : state_q;
    sec_d       = (mode_ev & is_run) ? 8'h00 : tick ? bcd_inc(sec_q, 8'h59) : sec_q;
    min_d       = ((tick & sec_carry) | (set_inc & state_q == SET_M)) ? bcd_inc(min_q, 8'h59) : min_q;
    hour_d      = ((tick & sec_carry & min_carry) | (set_inc & state_q == SET_H)) ? bcd_inc(hour_q, HOUR_TOP) : hour_q;
    alarm_match = tick & alarm_en & sec_carry & (min_d == alarm_m) & (hour_d == alarm_h);
    alarm_stop  = ~alarm_en | (inc_ev & is_run) | mode_ev;
    alarm_cnt_d = alarm_stop ? 8'd0 : alarm_match ? ALARM_LOAD : (tick & alarm_active) ? alarm_cnt_q - 8'd1 : alarm_cnt_q;
    sec_pulse_d = tick;
    beep_d      = tick_beep & alarm_active;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_s_q    <= 1'b0;
      key_mode_q  <= 1'b0;
      key_inc_q   <= 1'b0;
      state_q     <= RUN;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      alarm_cnt_q <= 8'd0;
      sec_pulse_q <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      tick_s_q    <= tick_s;
      key_mode_q  <= key_mode;
      key_inc_q   <= key_inc;
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      alarm_cnt_q <= alarm_cnt_d;
      sec_pulse_q <= sec_pulse_d;
      beep_q      <= beep_d;
    end
  end

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign set_mode  = state_q;
  assign sec_pulse = sec_pulse_q;
  assign beep      = beep_q;
endmodule

// File: tb/tb_clock_time_core.sv
// tb_clock_time_core: scoreboard bench for the timekeeping core
module tb_clock_time_core;
  logic       clk, reset, tick_s, tick_beep, key_mode, key_inc, alarm_en;
  logic [7:0] alarm_h, alarm_m, hour_bcd, min_bcd, sec_bcd;
  logic [1:0] set_mode;
  logic       sec_pulse, beep;

  int          checks = 0, errors = 0, pulses = 0;
  int          m_h = 0, m_m = 0, m_s = 0, m_mode = 0;
  logic [31:0] sb[$];
  logic        prev_pulse = 1'b0, beep_seen = 1'b0;

  clock_time_core dut (
    .clk(clk), .reset(reset), .tick_s(tick_s), .tick_beep(tick_beep),
    .key_mode(key_mode), .key_inc(key_inc), .alarm_en(alarm_en),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .hour_bcd(hour_bcd),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .set_mode(set_mode),
    .sec_pulse(sec_pulse), .beep(beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [31:0] tv(input int h, input int m, input int s);
    return {8'h00, to_bcd(h), to_bcd(m), to_bcd(s)};
  endfunction

  function automatic logic digits_ok(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return a[3:0] < 10 && a[7:4] < 10 && b[3:0] < 10 && b[7:4] < 10 && c[3:0] < 10 && c[7:4] < 10;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
    sb.delete();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_s = 1'b1;
      if (m_mode == 0) begin
        m_s++;
        if (m_s == 60) begin m_s = 0; m_m++; end
        if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
        sb.push_back(tv(m_h, m_m, m_s));
      end
      cyc(1);
      tick_s = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press(input logic md, input logic inc, input int n);
    for (int i = 0; i < n; i++) begin
      key_mode = md;
      key_inc  = inc;
      if (md) begin
        m_mode = (m_mode + 1) % 3;
        if (m_mode == 1) m_s = 0;
      end else if (m_mode == 1) m_m = (m_m + 1) % 60;
      else if (m_mode == 2) m_h = (m_h + 1) % 24;
      cyc(1);
      key_mode = 1'b0;
      key_inc  = 1'b0;
      cyc(1);
    end
  endtask

  task automatic check_time(input string tag);
    check(tag, {8'h00, hour_bcd, min_bcd, sec_bcd}, tv(m_h, m_m, m_s));
    check({tag, "_mode"}, 32'(set_mode), 32'(m_mode));
  endtask

  always @(negedge clk) begin
    if (beep) beep_seen = 1'b1;
    if (sec_pulse) begin
      pulses++;
      check("pulse_width", 32'(prev_pulse), 32'd0);
      check("bcd_digits", 32'(digits_ok(hour_bcd, min_bcd, sec_bcd)), 32'd1);
      if (sb.size() == 0) check("pulse_unexpected", 32'd1, 32'd0);
      else check("sb_time", {8'h00, hour_bcd, min_bcd, sec_bcd}, sb.pop_front());
    end
    prev_pulse = sec_pulse;
  end

  initial begin
    reset = 1'b0; tick_s = 1'b0; tick_beep = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    alarm_en = 1'b0; alarm_h = 8'h00; alarm_m = 8'h00;
    cyc(3);
    check_time("reset_time");
    check("reset_pulse", 32'(sec_pulse), 32'd0);
    check("reset_beep", 32'(beep), 32'd0);
    reset = 1'b1;
    cyc(1);

    pulses = 0;
    tick(60);
    check_time("one_minute");
    check("pulse_count", 32'(pulses), 32'd60);

    tick(5);
    key_mode = 1'b1; m_mode = 1; m_s = 0;
    cyc(100);
    key_mode = 1'b0;
    cyc(1);
    check_time("mode_hold");
    press(1'b0, 1'b1, 56);
    check_time("min_57");
    press(1'b0, 1'b1, 5);
    check_time("min_wrap_02");
    tick(3);
    check_time("setm_ticks_ignored");

    press(1'b0, 1'b1, 57);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 23);
    press(1'b1, 1'b0, 1);
    check_time("preload_2359");
    tick(60);
    check_time("day_wrap");

    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 29);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 7);
    press(1'b1, 1'b0, 1);
    alarm_h = 8'h07; alarm_m = 8'h30; alarm_en = 1'b1;
    tick(59);
    check_time("pre_alarm");
    check("pre_alarm_beep", 32'(beep), 32'd0);
    tick(1);
    tick_beep = 1'b1;
    check("beep_latency", 32'(beep), 32'd0);
    cyc(1);
    check("beep_follow_hi", 32'(beep), 32'd1);
    tick_beep = 1'b0;
    cyc(1);
    check("beep_follow_lo", 32'(beep), 32'd0);
    tick_beep = 1'b1;
    tick(59);
    check("beep_last_sec", 32'(beep), 32'd1);
    tick(1);
    check("beep_expired", 32'(beep), 32'd0);
    check_time("alarm_end_time");

    alarm_m = 8'h32;
    tick(60);
    check("beep_second_alarm", 32'(beep), 32'd1);
    key_inc = 1'b1;
    cyc(1);
    key_inc = 1'b0;
    cyc(1);
    check("beep_inc_stop", 32'(beep), 32'd0);
    cyc(3);
    check("beep_stays_off", 32'(beep), 32'd0);
    check_time("inc_in_run");
    tick(1);
    check("beep_no_restart", 32'(beep), 32'd0);

    alarm_en = 1'b0; alarm_m = 8'h33;
    beep_seen = 1'b0;
    tick(59);
    cyc(3);
    check("disabled_no_beep", 32'(beep_seen), 32'd0);
    check_time("disabled_match_time");

    key_mode = 1'b1; key_inc = 1'b1; m_mode = 1; m_s = 0;
    cyc(1);
    key_mode = 1'b0; key_inc = 1'b0;
    cyc(1);
    check_time("both_to_setm");
    key_mode = 1'b1; key_inc = 1'b1; m_mode = 2;
    cyc(1);
    key_mode = 1'b0; key_inc = 1'b0;
    cyc(1);
    check_time("both_to_seth");
    key_mode = 1'b1; key_inc = 1'b1; m_mode = 0;
    cyc(1);
    key_mode = 1'b0; key_inc = 1'b0;
    cyc(1);
    check_time("both_to_run");

    alarm_en = 1'b1; alarm_m = 8'h34;
    tick(60);
    check("beep_before_reset", 32'(beep), 32'd1);
    reset = 1'b0;
    cyc(1);
    model_reset();
    check_time("reset_alarm_time");
    check("reset_alarm_beep", 32'(beep), 32'd0);
    check("reset_alarm_pulse", 32'(sec_pulse), 32'd0);
    reset = 1'b1;
    cyc(3);
    check("beep_after_reset", 32'(beep), 32'd0);

    press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 3);
    check_time("seth_hour_3");
    reset = 1'b0;
    cyc(1);
    model_reset();
    check_time("reset_in_seth");
    check("reset_seth_beep", 32'(beep), 32'd0);
    reset = 1'b1;
    cyc(1);
    tick(2);
    check_time("post_reset_run");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
